mem_arbiter: RTL and testbench

- Shares one single-port, variable-latency unified memory between the core's instruction-fetch port and its load/store port.
- Sits between the MIPS core (instr/readdata/writedata/memwrite side) and the memory. The core stalls on each port until that port's ack.
- Round-robin arbitration, per-transaction timeout, and misalignment error reporting.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter_timeout.sv | 36 +++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/load-store memory arbiter:
// FSM and grant encodings, default data width, round-robin pick helper.
package mem_arbiter_pkg;

  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_gnt_t;

  // On a tie the port that did not win last time goes next.
  function automatic arb_gnt_t rr_pick(input logic i_v, input logic d_v, input arb_gnt_t last);
    if (i_v && d_v) begin
      return (last == GNT_I) ? GNT_D : GNT_I;
    end else if (d_v) begin
      return GNT_D;
    end else begin
      return GNT_I;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's two ports, the arbiter and the unified memory.
interface mem_arbiter_if #(
  parameter int DATA_W = mem_arbiter_pkg::ARB_DATA_W
);
  // Handshake: x_req is a level held until the single-cycle x_ack (x_err/x_rdata
  // valid only with it); mem_req is held with stable mem_addr/mem_we/mem_wdata
  // until mem_ready (sampled only while mem_req=1) or a timeout abort.
  logic              i_req;
  logic [DATA_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_err;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Arbiter view.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // Core and memory view.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_timeout.sv
// Per-transaction wait counter; `expired` is high once the count reaches
// TIMEOUT_CYC. A TIMEOUT_CYC of 0 means the counter never expires.
module arb_timeout #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT_CYC != 0) && (cnt_q == TO_W'(TIMEOUT_CYC));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port, variable-latency memory between
// instruction fetch and load/store, with misalignment and timeout error reporting.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W      = ARB_DATA_W,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_arbiter_if.slave        bus,
  output logic                busy,
  output arb_state_t          dbg_state
);

  arb_state_t        state_q, state_d;
  arb_gnt_t          last_q, last_d;
  logic              mask_q, mask_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              i_err_q, i_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic              i_v, d_v;
  arb_gnt_t          gnt;
  logic [DATA_W-1:0] g_addr;
  logic              resp_v, resp_err;
  logic [DATA_W-1:0] resp_data;
  arb_gnt_t          resp_port;

  logic in_busy;
  logic to_clr, to_inc, to_expired;

  assign in_busy = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);
  assign to_clr  = (state_q == ARB_RESP);
  assign to_inc  = in_busy && !bus.mem_ready && !to_expired;

  arb_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (to_clr),
    .inc     (to_inc),
    .expired (to_expired)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mask_d      = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;

    // The port acked last cycle may still hold its req for one more cycle.
    i_v    = bus.i_req && !(mask_q && (last_q == GNT_I));
    d_v    = bus.d_req && !(mask_q && (last_q == GNT_D));
    gnt    = rr_pick(i_v, d_v, last_q);
    g_addr = (gnt == GNT_I) ? bus.i_addr : bus.d_addr;

    resp_v    = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    resp_port = last_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (i_v || d_v) begin
          last_d      = gnt;
          resp_port   = gnt;
          mem_addr_d  = g_addr;
          mem_we_d    = (gnt == GNT_D) && bus.d_we;
          mem_wdata_d = (gnt == GNT_D) ? bus.d_wdata : '0;
          if (g_addr[1:0] != 2'b00) begin
            state_d  = ARB_RESP;
            resp_v   = 1'b1;
            resp_err = 1'b1;
          end else begin
            state_d   = (gnt == GNT_I) ? ARB_BUSY_I : ARB_BUSY_D;
            mem_req_d = 1'b1;
          end
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (bus.mem_ready) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          resp_v    = 1'b1;
          resp_data = mem_we_q ? '0 : bus.mem_rdata;
        end else if (to_expired) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          resp_v    = 1'b1;
          resp_err  = 1'b1;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        mask_d  = 1'b1;
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (resp_v) begin
      if (resp_port == GNT_I) begin
        i_ack_d   = 1'b1;
        i_err_d   = resp_err;
        i_rdata_d = resp_data;
      end else begin
        d_ack_d   = 1'b1;
        d_err_d   = resp_err;
        d_rdata_d = resp_data;
      end
    end

    busy_d = (state_d == ARB_BUSY_I) || (state_d == ARB_BUSY_D);
  end

  // last_q resets to D so the first tie after reset goes to fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      last_q      <= GNT_D;
      mask_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mask_q      <= mask_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_err_q     <= i_err_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_err     = i_err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: load, tie round-robin, store, misaligned,
// timeout with late ready, and asynchronous reset in the middle of a transaction.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int W = 33;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  arb_state_t dbg_state;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(32)) bus ();

  mem_arbiter #(
    .DATA_W      (32),
    .TIMEOUT_CYC (4),
    .TO_W        (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int both_ack = 0;
  int req_bad  = 0;
  int req_cycles = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  // Protocol monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.i_ack && bus.d_ack) both_ack++;
      if (bus.mem_req) begin
        req_cycles++;
        if (dbg_state == ARB_IDLE || dbg_state == ARB_RESP) req_bad++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    int acks;
    int last_ack;
    int gap_bad;
    int hi;
    int budget;
    int req_snap;

    idle_inputs();
    step();
    step();
    // ---------------- reset state
    check("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_i_ack",   {31'b0, bus.i_ack}, 32'd0);
    check("rst_d_ack",   {31'b0, bus.d_ack}, 32'd0);
    check("rst_busy",    {31'b0, busy}, 32'd0);
    check("rst_state",   {30'b0, dbg_state}, {30'b0, ARB_IDLE});
    rst_n = 1'b1;
    step();

    // ---------------- tie after reset: I, D, I, D every 3 cycles
    bus.i_addr = 32'h10;
    bus.d_addr = 32'h20;
    bus.d_we   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    exp_q.push_back({1'b0, 32'hC0DE0010});
    exp_q.push_back({1'b1, 32'hC0DE0020});
    exp_q.push_back({1'b0, 32'hC0DE0010});
    exp_q.push_back({1'b1, 32'hC0DE0020});
    acks = 0;
    last_ack = -1;
    gap_bad = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.i_ack || bus.d_ack) begin
        got = bus.i_ack ? {1'b0, bus.i_rdata} : {1'b1, bus.d_rdata};
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tie_port",  {31'b0, got[32]}, {31'b0, e[32]});
          check("tie_rdata", got[31:0], e[31:0]);
        end
        if (acks == 0 && k != 1) gap_bad++;
        if (last_ack >= 0 && (k - last_ack) != 3) gap_bad++;
        last_ack = k;
        acks++;
      end
      bus.mem_ready = bus.mem_req;
      bus.mem_rdata = 32'hC0DE0000 | bus.mem_addr;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.mem_ready = 1'b0;
    check("tie_acks", acks, 32'd4);
    check("tie_gap", gap_bad, 32'd0);
    check("tie_q_empty", exp_q.size(), 32'd0);
    step();
    step();

    // ---------------- single load
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h40;
    bus.d_we   = 1'b0;
    step();
    check("ld_mem_req",  {31'b0, bus.mem_req}, 32'd1);
    check("ld_mem_addr", bus.mem_addr, 32'h40);
    check("ld_mem_we",   {31'b0, bus.mem_we}, 32'd0);
    check("ld_busy",     {31'b0, busy}, 32'd1);
    check("ld_ack_early", {31'b0, bus.d_ack}, 32'd0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    step();
    check("ld_ack",    {31'b0, bus.d_ack}, 32'd1);
    check("ld_rdata",  bus.d_rdata, 32'hDEADBEEF);
    check("ld_err",    {31'b0, bus.d_err}, 32'd0);
    check("ld_req_dn", {31'b0, bus.mem_req}, 32'd0);
    bus.mem_ready = 1'b0;
    bus.d_req = 1'b0;
    step();
    check("ld_ack_pulse", {31'b0, bus.d_ack}, 32'd0);
    check("ld_rdata_hold", bus.d_rdata, 32'hDEADBEEF);
    step();

    // ---------------- store held for two cycles before ready
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h100;
    bus.d_wdata = 32'h12345678;
    step();
    check("st_mem_we",    {31'b0, bus.mem_we}, 32'd1);
    check("st_mem_addr",  bus.mem_addr, 32'h100);
    check("st_mem_wdata", bus.mem_wdata, 32'h12345678);
    bus.d_wdata = 32'hFFFF0000;
    step();
    step();
    check("st_req_held",   {31'b0, bus.mem_req}, 32'd1);
    check("st_wdata_held", bus.mem_wdata, 32'h12345678);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    step();
    check("st_ack",   {31'b0, bus.d_ack}, 32'd1);
    check("st_rdata", bus.d_rdata, 32'h0);
    check("st_err",   {31'b0, bus.d_err}, 32'd0);
    bus.mem_ready = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    step();
    step();

    // ---------------- misaligned fetch
    req_snap = req_cycles;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0006;
    step();
    check("mis_ack",   {31'b0, bus.i_ack}, 32'd1);
    check("mis_err",   {31'b0, bus.i_err}, 32'd1);
    check("mis_rdata", bus.i_rdata, 32'h0);
    bus.i_req = 1'b0;
    step();
    check("mis_ack_dn", {31'b0, bus.i_ack}, 32'd0);
    check("mis_err_dn", {31'b0, bus.i_err}, 32'd0);
    step();
    check("mis_no_req", req_cycles - req_snap, 32'd0);

    // ---------------- timeout (TIMEOUT_CYC = 4)
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h200;
    bus.d_we   = 1'b0;
    hi = 0;
    budget = 0;
    step();
    while (!bus.d_ack && budget < 30) begin
      if (bus.mem_req) hi++;
      step();
      budget++;
    end
    check("to_acked",     {31'b0, bus.d_ack}, 32'd1);
    check("to_req_cycles", hi, 32'd5);
    check("to_err",       {31'b0, bus.d_err}, 32'd1);
    check("to_rdata",     bus.d_rdata, 32'h0);
    bus.d_req = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    step();
    check("late_ack_a", {31'b0, bus.d_ack}, 32'd0);
    step();
    check("late_ack_b", {31'b0, bus.d_ack}, 32'd0);
    check("late_req",   {31'b0, bus.mem_req}, 32'd0);
    check("late_state", {30'b0, dbg_state}, {30'b0, ARB_IDLE});
    bus.mem_ready = 1'b0;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h44;
    step();
    check("post_to_req", {31'b0, bus.mem_req}, 32'd1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h55AA55AA;
    step();
    check("post_to_ack",   {31'b0, bus.d_ack}, 32'd1);
    check("post_to_rdata", bus.d_rdata, 32'h55AA55AA);
    check("post_to_err",   {31'b0, bus.d_err}, 32'd0);
    bus.mem_ready = 1'b0;
    bus.d_req = 1'b0;
    step();
    step();

    // ---------------- asynchronous reset during BUSY_D
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h80;
    step();
    step();
    check("rm_busy_d", {30'b0, dbg_state}, {30'b0, ARB_BUSY_D});
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_req_async", {31'b0, bus.mem_req}, 32'd0);
    check("rm_no_ack",    {31'b0, bus.d_ack}, 32'd0);
    check("rm_state",     {30'b0, dbg_state}, {30'b0, ARB_IDLE});
    bus.d_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    bus.i_addr = 32'h30;
    bus.d_addr = 32'h34;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    step();
    check("rm_tie_state", {30'b0, dbg_state}, {30'b0, ARB_BUSY_I});
    check("rm_tie_addr",  bus.mem_addr, 32'h30);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h77;
    step();
    check("rm_i_ack",   {31'b0, bus.i_ack}, 32'd1);
    check("rm_i_rdata", bus.i_rdata, 32'h77);
    check("rm_d_ack",   {31'b0, bus.d_ack}, 32'd0);
    bus.mem_ready = 1'b0;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step();
    step();

    check("never_both_ack", both_ack, 32'd0);
    check("req_only_busy",  req_bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
